// File: rtl/arm_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arm_regfile : banked ARM7 register file with CPSR and per-mode SPSRs.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module arm_regfile #(
    parameter logic [31:0] RESET_CPSR = 32'h000000D3,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [3:0]  read_reg,
    output logic [31:0] read_value,
    input  logic        write_en,
    input  logic [3:0]  write_reg,
    input  logic [31:0] write_value,
    input  logic        write_restore_from_SPSR,
    input  logic        mode_read_en,
    output logic [2:0]  mode_read_value,
    input  logic        cpsr_read_en,
    output logic [31:0] cpsr_read_value,
    input  logic        cpsr_write_en,
    input  logic [31:0] cpsr_write_value,
    input  logic        spsr_read_en,
    output logic [31:0] spsr_read_value,
    input  logic        spsr_write_en,
    input  logic [31:0] spsr_write_value,
    output logic [31:0] pc_value
);

    localparam logic [2:0] c_MODE_USR = 3'd0;
    localparam logic [2:0] c_MODE_SYS = 3'd1;
    localparam logic [2:0] c_MODE_FIQ = 3'd2;
    localparam logic [2:0] c_MODE_IRQ = 3'd3;
    localparam logic [2:0] c_MODE_SVC = 3'd4;
    localparam logic [2:0] c_MODE_ABT = 3'd5;
    localparam logic [2:0] c_MODE_UND = 3'd6;

    function automatic logic [2:0] decode_mode(input logic [4:0] m);
        case (m)
            5'b10000: decode_mode = c_MODE_USR;
            5'b11111: decode_mode = c_MODE_SYS;
            5'b10001: decode_mode = c_MODE_FIQ;
            5'b10010: decode_mode = c_MODE_IRQ;
            5'b10011: decode_mode = c_MODE_SVC;
            5'b10111: decode_mode = c_MODE_ABT;
            5'b11011: decode_mode = c_MODE_UND;
            default:  decode_mode = c_MODE_USR;
        endcase
    endfunction

    logic [31:0] r_lo     [0:7];
    logic [31:0] r_hi_usr [0:4];
    logic [31:0] r_hi_fiq [0:4];
    // Bank 0 serves USR/SYS; banks 1..5 serve FIQ, IRQ, SVC, ABT, UND.
    logic [31:0] r_sp     [0:5];
    logic [31:0] r_lr     [0:5];
    logic [31:0] r_spsr   [0:5];
    logic [31:0] r_pc;
    logic [31:0] r_cpsr;
    logic [31:0] r_read_value;
    logic [31:0] r_cpsr_read_value;
    logic [31:0] r_spsr_read_value;
    logic [2:0]  r_mode_read_value;

    logic [2:0]  w_mode;
    logic        w_exc;
    logic        w_fiq;
    logic [2:0]  w_bank;
    logic        w_restore;
    logic [31:0] w_rd_data;
    logic [31:0] w_spsr_rd;

    assign w_mode    = decode_mode(r_cpsr[4:0]);
    assign w_exc     = (w_mode >= c_MODE_FIQ);
    assign w_fiq     = (w_mode == c_MODE_FIQ);
    assign w_bank    = w_exc ? (w_mode - 3'd1) : 3'd0;
    assign w_restore = write_en && (write_reg == 4'd15) && write_restore_from_SPSR && w_exc;
    assign w_spsr_rd = w_exc ? (spsr_write_en ? spsr_write_value : r_spsr[w_bank]) : r_cpsr;

    always_comb begin
        w_rd_data = '0;
        if (!read_reg[3]) begin
            w_rd_data = r_lo[read_reg[2:0]];
        end else begin
            case (read_reg[2:0])
                3'd5:    w_rd_data = r_sp[w_bank];
                3'd6:    w_rd_data = r_lr[w_bank];
                3'd7:    w_rd_data = r_pc;
                default: w_rd_data = w_fiq ? r_hi_fiq[read_reg[2:0]] : r_hi_usr[read_reg[2:0]];
            endcase
        end
        // Same index in the same mode is the same physical register.
        if (write_en && (write_reg == read_reg))
            w_rd_data = write_value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_lo[i] <= '0;
            for (int i = 0; i < 5; i++) begin
                r_hi_usr[i] <= '0;
                r_hi_fiq[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                r_sp[i]   <= '0;
                r_lr[i]   <= '0;
                r_spsr[i] <= '0;
            end
            r_pc              <= RESET_PC;
            r_cpsr            <= RESET_CPSR;
            r_read_value      <= '0;
            r_cpsr_read_value <= '0;
            r_spsr_read_value <= '0;
            r_mode_read_value <= '0;
        end else begin
            if (write_en) begin
                if (!write_reg[3]) begin
                    r_lo[write_reg[2:0]] <= write_value;
                end else begin
                    case (write_reg[2:0])
                        3'd5:    r_sp[w_bank] <= write_value;
                        3'd6:    r_lr[w_bank] <= write_value;
                        3'd7:    r_pc         <= write_value;
                        default: begin
                            if (w_fiq) r_hi_fiq[write_reg[2:0]] <= write_value;
                            else       r_hi_usr[write_reg[2:0]] <= write_value;
                        end
                    endcase
                end
            end
            if (cpsr_write_en)
                r_cpsr <= cpsr_write_value;
            else if (w_restore)
                r_cpsr <= r_spsr[w_bank];
            if (spsr_write_en && w_exc)
                r_spsr[w_bank] <= spsr_write_value;
            if (read_en)      r_read_value      <= w_rd_data;
            if (cpsr_read_en) r_cpsr_read_value <= cpsr_write_en ? cpsr_write_value : r_cpsr;
            if (spsr_read_en) r_spsr_read_value <= w_spsr_rd;
            if (mode_read_en) r_mode_read_value <= w_mode;
        end
    end

    assign read_value      = r_read_value;
    assign cpsr_read_value = r_cpsr_read_value;
    assign spsr_read_value = r_spsr_read_value;
    assign mode_read_value = r_mode_read_value;
    assign pc_value        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_arm_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arm_regfile : directed and random checks against a mode/register map. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_arm_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, write_en, write_restore_from_SPSR;
    logic [3:0]  read_reg, write_reg;
    logic [31:0] read_value, write_value;
    logic        mode_read_en;
    logic [2:0]  mode_read_value;
    logic        cpsr_read_en, cpsr_write_en, spsr_read_en, spsr_write_en;
    logic [31:0] cpsr_read_value, cpsr_write_value, spsr_read_value, spsr_write_value;
    logic [31:0] pc_value;

    always #5 clk = ~clk;

    arm_regfile dut (
        .clk(clk), .rst(rst),
        .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .write_restore_from_SPSR(write_restore_from_SPSR),
        .mode_read_en(mode_read_en), .mode_read_value(mode_read_value),
        .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
        .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
        .spsr_read_en(spsr_read_en), .spsr_read_value(spsr_read_value),
        .spsr_write_en(spsr_write_en), .spsr_write_value(spsr_write_value),
        .pc_value(pc_value)
    );

    // Reference state: a flat store keyed by physical register identity.
    logic [31:0] m_reg [64];
    logic [31:0] m_spsr [7];
    logic [31:0] m_cpsr;
    logic [31:0] e_read, e_cpsr, e_spsr, e_pc;
    logic [2:0]  e_mode;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic int mode_of(input logic [4:0] m);
        case (m)
            5'h10: return 0;
            5'h1F: return 1;
            5'h11: return 2;
            5'h12: return 3;
            5'h13: return 4;
            5'h17: return 5;
            5'h1B: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic int phys(input int md, input int r);
        if (r >= 8 && r <= 12) return (md == 2) ? 16 + r : r;
        if (r == 13 || r == 14) return (md <= 1) ? r : 32 + md * 2 + (r - 13);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rst = 0; read_en = 0; read_reg = 0; write_en = 0; write_reg = 0; write_value = 0;
        write_restore_from_SPSR = 0; mode_read_en = 0; cpsr_read_en = 0; cpsr_write_en = 0;
        cpsr_write_value = 0; spsr_read_en = 0; spsr_write_en = 0; spsr_write_value = 0;
    endtask

    // Predict from pre-edge state, clock once, compare every output.
    task automatic cyc();
        int md;
        logic [31:0] nc;
        md = mode_of(m_cpsr[4:0]);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            foreach (m_spsr[i]) m_spsr[i] = 0;
            m_cpsr = 32'hD3;
            e_read = 0; e_cpsr = 0; e_spsr = 0; e_mode = 0;
        end else begin
            if (read_en)
                e_read = (write_en && write_reg == read_reg) ? write_value
                                                              : m_reg[phys(md, int'(read_reg))];
            if (cpsr_read_en) e_cpsr = cpsr_write_en ? cpsr_write_value : m_cpsr;
            if (spsr_read_en)
                e_spsr = (md >= 2) ? (spsr_write_en ? spsr_write_value : m_spsr[md]) : m_cpsr;
            if (mode_read_en) e_mode = 3'(md);
            nc = m_cpsr;
            if (cpsr_write_en) nc = cpsr_write_value;
            else if (write_en && write_reg == 15 && write_restore_from_SPSR && md >= 2) nc = m_spsr[md];
            if (write_en) m_reg[phys(md, int'(write_reg))] = write_value;
            if (spsr_write_en && md >= 2) m_spsr[md] = spsr_write_value;
            m_cpsr = nc;
        end
        e_pc = m_reg[15];
        @(posedge clk);
        #1;
        chk("read_value", read_value, e_read);
        chk("cpsr_read_value", cpsr_read_value, e_cpsr);
        chk("spsr_read_value", spsr_read_value, e_spsr);
        chk("mode_read_value", {29'd0, mode_read_value}, {29'd0, e_mode});
        chk("pc_value", pc_value, e_pc);
        clr();
    endtask

    task automatic wr(input logic [3:0] r, input logic [31:0] v);
        write_en = 1; write_reg = r; write_value = v; cyc();
    endtask
    task automatic rd(input logic [3:0] r);
        read_en = 1; read_reg = r; cyc();
    endtask
    task automatic cpw(input logic [31:0] v);
        cpsr_write_en = 1; cpsr_write_value = v; cyc();
    endtask

    logic [4:0]  modes [8] = '{5'h10, 5'h1F, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h05};
    logic [31:0] t;

    initial begin
        clr();
        m_cpsr = 32'hD3;
        foreach (m_reg[i]) m_reg[i] = 0;
        foreach (m_spsr[i]) m_spsr[i] = 0;
        // Reset state
        rst = 1; cyc();
        chk("rst_pc", pc_value, 32'h0);
        cpsr_read_en = 1; cyc();
        chk("rst_cpsr", cpsr_read_value, 32'hD3);
        mode_read_en = 1; cyc();
        chk("rst_mode", {29'd0, mode_read_value}, 32'd4);
        // Banking of R13 between SVC and IRQ
        wr(4'd13, 32'h1111);
        cpw(32'hD2);
        wr(4'd13, 32'h2222);
        rd(4'd13); chk("bank_irq_r13", read_value, 32'h2222);
        cpw(32'hD3);
        rd(4'd13); chk("bank_svc_r13", read_value, 32'h1111);
        // FIQ R8 banking
        cpw(32'hD0);
        wr(4'd8, 32'd5);
        cpw(32'hD1);
        rd(4'd8); chk("fiq_r8_init", read_value, 32'd0);
        wr(4'd8, 32'd7);
        cpw(32'hD0);
        rd(4'd8); chk("usr_r8", read_value, 32'd5);
        // SPSR restore through R15 write
        cpw(32'hD3);
        spsr_write_en = 1; spsr_write_value = 32'h60000010; cyc();
        write_en = 1; write_reg = 15; write_value = 32'h100; write_restore_from_SPSR = 1; cyc();
        chk("restore_pc", pc_value, 32'h100);
        cpsr_read_en = 1; cyc(); chk("restore_cpsr", cpsr_read_value, 32'h60000010);
        mode_read_en = 1; cyc(); chk("restore_mode", {29'd0, mode_read_value}, 32'd0);
        // Collisions
        write_en = 1; write_reg = 3; write_value = 32'hABCD; read_en = 1; read_reg = 3; cyc();
        chk("bypass_r3", read_value, 32'hABCD);
        cpw(32'hD3);
        spsr_write_en = 1; spsr_write_value = 32'hD0; cyc();
        write_en = 1; write_reg = 15; write_value = 32'h200; write_restore_from_SPSR = 1;
        cpsr_write_en = 1; cpsr_write_value = 32'hD7; cyc();
        cpsr_read_en = 1; cyc(); chk("cpsr_prio", cpsr_read_value, 32'hD7);
        // Reset wins over a same-cycle write
        wr(4'd0, 32'd1);
        rst = 1; write_en = 1; write_reg = 0; write_value = 32'd9; cyc();
        rd(4'd0); chk("rst_r0", read_value, 32'd0);
        // Random traffic
        for (int k = 0; k < 600; k++) begin
            read_en = 1'($urandom); read_reg = 4'($urandom);
            write_en = 1'($urandom); write_reg = 4'($urandom); write_value = $urandom;
            write_restore_from_SPSR = ($urandom % 3 == 0);
            mode_read_en = 1'($urandom); cpsr_read_en = 1'($urandom); spsr_read_en = 1'($urandom);
            cpsr_write_en = ($urandom % 5 == 0);
            t = $urandom;
            cpsr_write_value = {t[31:5], modes[$urandom % 8]};
            spsr_write_en = ($urandom % 4 == 0);
            t = $urandom;
            spsr_write_value = {t[31:5], modes[$urandom % 8]};
            rst = ($urandom % 80 == 0);
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
